ring_buffer_param: RTL
======================

Name: ring_buffer_param

Overview:
Parametrised circular buffer built on a register array. Write pointer auto-increments, read pointer trails it, and the block reports full, empty and fill level. Adds a selectable overwrite-when-full mode, sticky overflow/underflow flags and a wrapping accepted-write counter. Sits between a streaming producer and a consumer in the datapath.

Parameters:
DATA_W, 8, width of each stored word
DEPTH, 16, number of entries; power of two, at least 2
ADDR_W, $clog2(DEPTH), pointer width (derived; do not override)
CNT_W, 8, width of the accepted-write counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous, active-low (0 = reset, sampled on rising clk)
wr_en  in  1  write request
wr_data  in  DATA_W  write word
rd_en  in  1  read request
overwrite  in  1  0 = drop writes when full; 1 = overwrite oldest entry when full
clr_flags  in  1  clears overflow/underflow sticky flags
rd_data  out  DATA_W  registered read word
rd_valid  out  1  rd_data valid this cycle
full  out  1  level == DEPTH
empty  out  1  level == 0
level  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was dropped, or an entry was overwritten
underflow  out  1  sticky: read requested while empty
wr_count  out  CNT_W  accepted writes, modulo 2^CNT_W

Behaviour:
- Reset (rst=0 at a rising edge): wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, wr_count=0. full=0 and empty=1. Array contents are not reset. Reset overrides all other inputs in the same cycle. Reset mid-stream discards all stored data.
- full and empty are combinational from level. level is registered.
- Read is accepted when rd_en=1 and empty=0. Then rd_data <= mem[rd_ptr] and rd_valid=1 on the next cycle. rd_ptr increments modulo DEPTH.
- rd_valid is a one-cycle pulse per accepted read. rd_data holds its value until the next accepted read.
- Read with empty=1: no pointer change, rd_valid=0 next cycle, underflow <= 1. This applies even if wr_en=1 in the same cycle; there is no write-to-read bypass.
- Write is accepted when wr_en=1 and any of the following holds:
  - full=0;
  - full=1 and a read is accepted in the same cycle;
  - full=1 and overwrite=1.
- On an accepted write: mem[wr_ptr] <= wr_data, wr_ptr increments modulo DEPTH, wr_count increments and wraps.
- Write with full=1, overwrite=0 and no accepted read: write dropped, overflow <= 1, nothing else changes.
- Write with full=1, overwrite=1 and no accepted read: write accepted, and rd_ptr also advances so the oldest entry is discarded. level stays DEPTH and overflow <= 1.
- Accepted read and accepted write in the same cycle: level unchanged. A full buffer with overwrite=1 plus a simultaneous read returns the oldest entry and does not set overflow.
- level update per cycle: +1 for an accepted write only; -1 for an accepted read only; 0 otherwise, including the overwrite case.
- Pointers wrap from DEPTH-1 to 0 with no other side effect.
- clr_flags=1 clears both sticky flags. A flag-setting event in the same cycle wins, so the flag stays 1.
- Read-to-data latency is 1 cycle. Write-to-readable latency is 1 cycle: the entry can be read the cycle after it is written.

Test Plan:
- Reset then fill: after rst, write 0x01..0x10 on 16 consecutive cycles -> full=1, level=16, wr_count=16. A 17th write with overwrite=0 is dropped and sets overflow=1.
- Drain order: from full, assert rd_en for 16 cycles -> rd_data 0x01..0x10 in order, each with a one-cycle rd_valid. empty=1 and level=0 afterward. One more rd_en -> underflow=1, rd_valid=0.
- Overwrite mode: fill with 0x01..0x10, set overwrite=1 and write 0xAA, 0xBB -> level=16, overflow=1. Draining yields 0x03..0x10, then 0xAA, 0xBB.
- Simultaneous read/write: at level=16 with overwrite=0, assert wr_en and rd_en together for 20 cycles -> level stays 16, overflow stays 0, reads return data in write order, and both pointers wrap.
- Mid-stream reset: at level=5, hold rst=0 for one edge -> level=0, empty=1, flags=0, wr_count=0. The next write/read pair returns the new word, not stale data.
- Flag clear race: assert clr_flags together with a dropped write -> overflow remains 1. Assert clr_flags alone on the next cycle -> overflow=0.

Source files
------------

// File: rtl/ring_buffer_param_if.sv
// rtl/ring_buffer_param_if.sv - producer/consumer bundle for the parametrised ring buffer
interface ring_buffer_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              overwrite;
  logic              clr_flags;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  wr_count;

  // Datapath side: drives requests, observes data and status.
  modport master (
    output wr_en, wr_data, rd_en, overwrite, clr_flags,
    input  rd_data, rd_valid, full, empty, level, overflow, underflow, wr_count
  );

  // Buffer side.
  modport slave (
    input  wr_en, wr_data, rd_en, overwrite, clr_flags,
    output rd_data, rd_valid, full, empty, level, overflow, underflow, wr_count
  );
endinterface

// File: rtl/ring_buffer_param.sv
// rtl/ring_buffer_param.sv - register-array circular buffer with overwrite mode and sticky flags
module ring_buffer_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 8
) (
  input logic                clk,
  input logic                rst,
  ring_buffer_param_if.slave bus
);

  localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE    = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  wr_count;

  logic full;
  logic empty;
  logic rd_acc;
  logic rd_miss;
  logic wr_acc;
  logic wr_evict;
  logic wr_drop;

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);

  // Classify this cycle's requests; a read frees a slot, so it lets a write into a full buffer.
  always_comb begin
    rd_acc   = 1'b0;
    rd_miss  = 1'b0;
    wr_acc   = 1'b0;
    wr_evict = 1'b0;
    wr_drop  = 1'b0;
    rd_acc   = bus.rd_en && !empty;
    rd_miss  = bus.rd_en && empty;
    wr_acc   = bus.wr_en && (!full || rd_acc || bus.overwrite);
    wr_evict = bus.wr_en && full && bus.overwrite && !rd_acc;
    wr_drop  = bus.wr_en && full && !bus.overwrite && !rd_acc;
  end

  // Storage array; contents survive reset, only the pointers forget them.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers and occupancy; an eviction moves rd_ptr along with wr_ptr and leaves level at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc || wr_evict) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_acc && !rd_acc && !wr_evict) begin
        level <= level + LVL_ONE;
      end else if (rd_acc && !wr_acc) begin
        level <= level - LVL_ONE;
      end
    end
  end

  // Registered read port; rd_data holds until the next accepted read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

  // Sticky error flags; a setting event in the same cycle beats clr_flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow && !bus.clr_flags) || wr_drop || wr_evict;
      underflow <= (underflow && !bus.clr_flags) || rd_miss;
    end
  end

  // Accepted-write counter, free-running modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (wr_acc) begin
      wr_count <= wr_count + CNT_ONE;
    end
  end

  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.level     = level;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
  assign bus.wr_count  = wr_count;

endmodule
